// File: rtl/elc3_pkg.sv
// Shared types and defaults for the eLC-3 memory controller.
package elc3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } mem_state_t;

  localparam int unsigned DATA_W         = 16;
  localparam logic [15:0] ELC3_MMIO_ADDR = 16'hFFFF;

endpackage

// File: rtl/elc3_sync2.sv
// Two-flop synchronizer for asynchronous board inputs.
module elc3_sync2 #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/elc3_mem_ctrl.sv
// eLC-3 async SRAM access sequencer: IDLE -> SETUP -> ACCESS x WAIT_STATES -> DONE.
// Optional ELC3_MMIO_EN: MMIO_ADDR bypasses SRAM (SW read, Hex_Data write).
module elc3_mem_ctrl
  import elc3_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned SRAM_AW     = 20,
  parameter logic [15:0] MMIO_ADDR   = ELC3_MMIO_ADDR
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               MIO_EN,
  input  logic               R_W,
  input  logic [DATA_W-1:0]  MAR,
  input  logic [DATA_W-1:0]  MDR_Out,
  output logic [DATA_W-1:0]  Mem_Data,
  output logic               R,
  input  logic [DATA_W-1:0]  SW,
  output logic [DATA_W-1:0]  Hex_Data,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_UB_N,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0]  SRAM_DQ
);

  localparam int unsigned CNT_W = $clog2(WAIT_STATES + 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              be_n_q, be_n_d;
  logic              dq_oe_q, dq_oe_d;
  logic              r_q, r_d;
  logic              sram_act;
  logic              mmio_d;

`ifdef ELC3_MMIO_EN
  logic              mmio_q;
  logic [DATA_W-1:0] hex_q, hex_d;
  logic [DATA_W-1:0] sw_sync;

  elc3_sync2 #(.W(DATA_W)) u_sw_sync (
    .clk (Clk),
    .rst (Reset),
    .d   (SW),
    .q   (sw_sync)
  );
`endif

  // Next state, latched request and registered strobe values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    mem_data_d = mem_data_q;
`ifdef ELC3_MMIO_EN
    mmio_d     = mmio_q;
    hex_d      = hex_q;
`else
    mmio_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (MIO_EN) begin
          addr_d  = MAR;
          wdata_d = MDR_Out;
          rw_d    = R_W;
          state_d = SETUP;
`ifdef ELC3_MMIO_EN
          mmio_d  = (MAR == MMIO_ADDR);
          if (mmio_d) begin
            state_d = DONE;
            if (R_W) hex_d      = MDR_Out;
            else     mem_data_d = sw_sync;
          end
`endif
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(WAIT_STATES - 1);
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!rw_q) mem_data_d = SRAM_DQ;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes follow the state being entered so they change on the same edge
    sram_act = (state_d != IDLE) && !mmio_d;
    ce_n_d   = !sram_act;
    be_n_d   = !sram_act;
    oe_n_d   = !(sram_act && !rw_d && (state_d != DONE));
    we_n_d   = !(sram_act && rw_d && (state_d == ACCESS));
    dq_oe_d  = sram_act && rw_d;
    r_d      = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rw_q       <= 1'b0;
      mem_data_q <= '0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      be_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
      r_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      mem_data_q <= mem_data_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      be_n_q     <= be_n_d;
      dq_oe_q    <= dq_oe_d;
      r_q        <= r_d;
    end
  end

`ifdef ELC3_MMIO_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mmio_q <= 1'b0;
      hex_q  <= '0;
    end else begin
      mmio_q <= mmio_d;
      hex_q  <= hex_d;
    end
  end

  assign Hex_Data = hex_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{SW, MMIO_ADDR};
  assign Hex_Data   = '0;
`endif

  assign Mem_Data  = mem_data_q;
  assign R         = r_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_LB_N = be_n_q;
  assign SRAM_UB_N = be_n_q;
  assign SRAM_ADDR = SRAM_AW'(addr_q);
  assign SRAM_DQ   = dq_oe_q ? wdata_q : 'z;

endmodule

// File: tb/tb_elc3_mem_ctrl.sv
// Bench for elc3_mem_ctrl: async SRAM model plus a word-level memory reference.
module tb_elc3_mem_ctrl;

  localparam int unsigned WS = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MIO_EN, R_W;
  logic [15:0] MAR, MDR_Out, SW;
  logic [15:0] Mem_Data, Hex_Data;
  logic        SRAM_R;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;

  int tests = 0;
  int fails = 0;
  int viol  = 0;
  logic [15:0] exp_md  = 16'h0000;
  logic [15:0] exp_hex = 16'h0000;
  logic [15:0] ref_mem [int];

  elc3_mem_ctrl #(.WAIT_STATES(WS)) dut (
    .Clk(Clk), .Reset(Reset), .MIO_EN(MIO_EN), .R_W(R_W), .MAR(MAR), .MDR_Out(MDR_Out),
    .Mem_Data(Mem_Data), .R(SRAM_R), .SW(SW), .Hex_Data(Hex_Data),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_LB_N(SRAM_LB_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ)
  );

  always #5 Clk = ~Clk;

  // Async SRAM: drives on CE&OE with WE high, writes on the rising WE edge
  logic [15:0] sram [int];
  logic [15:0] sram_rd;
  logic        sram_drive;
  wire         dq_is_z = (SRAM_DQ === 16'hzzzz);

  assign sram_drive = (SRAM_CE_N === 1'b0) && (SRAM_OE_N === 1'b0) && (SRAM_WE_N === 1'b1);
  assign SRAM_DQ    = sram_drive ? sram_rd : 16'hzzzz;

  always @(SRAM_ADDR or sram_drive)
    sram_rd = sram.exists(int'(SRAM_ADDR)) ? sram[int'(SRAM_ADDR)] : (SRAM_ADDR[15:0] ^ 16'hA5A5);

  always @(posedge SRAM_WE_N)
    if (SRAM_CE_N === 1'b0) sram[int'(SRAM_ADDR)] = SRAM_DQ;

  always @(negedge Clk)
    if (Reset === 1'b0) begin
      if (SRAM_WE_N === 1'b0 && SRAM_OE_N === 1'b0) viol++;
      if ((SRAM_WE_N === 1'b0 || SRAM_OE_N === 1'b0) && SRAM_CE_N !== 1'b0) viol++;
    end

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : (a ^ 16'hA5A5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access; cycle k is the k-th cycle after the accepting edge (1 = SETUP)
  task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d);
    int          lat, rc;
    bit          mm, sram_k;
    logic [19:0] ce_o, oe_o, we_o, r_o, ce_e, oe_e, we_e, r_e, be_bad, adr_bad, dq_bad;
    logic [15:0] exp_rd, md_r, hex_r;
    string       tg;
    mm = 1'b0;
`ifdef ELC3_MMIO_EN
    mm = (a == 16'hFFFF);
`endif
    lat    = mm ? 1 : int'(WS) + 2;
    exp_rd = mm ? SW : ref_rd(a);
    tg     = $sformatf("%s@%h", w ? "wr" : "rd", a);
    {ce_o, oe_o, we_o, r_o, ce_e, oe_e, we_e, r_e, be_bad, adr_bad, dq_bad} = '0;
    for (int k = 1; k <= lat + 1; k++) begin
      sram_k  = !mm && (k <= lat);
      ce_e[k] = !sram_k;
      oe_e[k] = !(sram_k && !w && k <= lat - 1);
      we_e[k] = !(sram_k && w && k >= 2 && k <= lat - 1);
      r_e[k]  = (k == lat);
    end
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = w; MAR = a; MDR_Out = d;
    rc = -1; md_r = Mem_Data; hex_r = Hex_Data;
    for (int k = 1; k <= 16; k++) begin
      @(negedge Clk);
      sram_k     = !mm && (k <= lat);
      ce_o[k]    = SRAM_CE_N;
      oe_o[k]    = SRAM_OE_N;
      we_o[k]    = SRAM_WE_N;
      r_o[k]     = SRAM_R;
      be_bad[k]  = (SRAM_LB_N !== SRAM_CE_N) || (SRAM_UB_N !== SRAM_CE_N);
      adr_bad[k] = sram_k && (SRAM_ADDR !== {4'h0, a});
      if (w && sram_k)                    dq_bad[k] = (SRAM_DQ !== d);
      else if (!w && sram_k && k < lat)   dq_bad[k] = (SRAM_DQ !== exp_rd);
      else                                dq_bad[k] = !dq_is_z;
      if (k == 1) begin
        MIO_EN = 1'b0; R_W = ~w; MAR = 16'($urandom); MDR_Out = 16'($urandom);
      end
      if (SRAM_R && rc < 0) begin
        rc = k; md_r = Mem_Data; hex_r = Hex_Data;
      end
      if (rc > 0 && k == rc + 1) break;
    end
    if (w) begin
      if (mm) exp_hex = d;
      else    ref_mem[int'(a)] = d;
    end else begin
      exp_md = exp_rd;
    end
    chk({tg, " latency"}, rc, lat);
    chk({tg, " ce_n"}, ce_o, ce_e);
    chk({tg, " oe_n"}, oe_o, oe_e);
    chk({tg, " we_n"}, we_o, we_e);
    chk({tg, " r_pulse"}, r_o, r_e);
    chk({tg, " byte_en"}, be_bad, 0);
    chk({tg, " addr"}, adr_bad, 0);
    chk({tg, " dq"}, dq_bad, 0);
    chk({tg, " mem_data"}, md_r, exp_md);
    chk({tg, " hex_data"}, hex_r, exp_hex);
  endtask

  initial begin
    logic [15:0] pool [6];
    logic        bad;
    int          r1, r2, rcnt;
    pool = '{16'h3000, 16'h3001, 16'h3003, 16'h0000, 16'hFFFF, 16'h7ABC};
    SW = 16'hBEEF; MIO_EN = 1'b0; R_W = 1'b0; MAR = '0; MDR_Out = '0;
    Reset = 1'b0;
    #2 Reset = 1'b1;

    // Reset holds everything quiet regardless of requests
    bad = 1'b0;
    repeat (6) begin
      @(negedge Clk);
      bad |= (SRAM_CE_N !== 1'b1) || (SRAM_OE_N !== 1'b1) || (SRAM_WE_N !== 1'b1) ||
             (SRAM_LB_N !== 1'b1) || (SRAM_UB_N !== 1'b1) || !dq_is_z || (SRAM_R !== 1'b0) ||
             (Mem_Data !== 16'h0) || (Hex_Data !== 16'h0) || (SRAM_ADDR !== 20'h0);
      MIO_EN = 1'($urandom); R_W = 1'($urandom); MAR = 16'($urandom);
    end
    chk("reset_quiet", bad, 0);
    chk("reset_mem_data", Mem_Data, 16'h0000);
    @(negedge Clk);
    MIO_EN = 1'b0; Reset = 1'b0;

    access(1'b1, 16'h3000, 16'h1234);
    access(1'b0, 16'h3000, 16'h0000);

    // Back-to-back with MIO_EN held: read then write, one IDLE between
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = 1'b0; MAR = 16'h3000;
    r1 = -1; r2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      if (SRAM_R) begin
        if (r1 < 0) begin
          r1 = k;
          chk("b2b first mem_data", Mem_Data, 16'h1234);
          R_W = 1'b1; MAR = 16'h3001; MDR_Out = 16'h5678;
        end else begin
          r2 = k;
          MIO_EN = 1'b0;
          break;
        end
      end
    end
    chk("b2b first latency", r1, WS + 2);
    chk("b2b gap", r2 - r1, WS + 3);
    ref_mem[int'(16'h3001)] = 16'h5678;
    exp_md = 16'h1234;
    access(1'b0, 16'h3001, 16'h0000);
    access(1'b0, 16'h3000, 16'h0000);

    // Reset in the second ACCESS cycle of a write aborts it
    @(negedge Clk);
    MIO_EN = 1'b1; R_W = 1'b1; MAR = 16'h3002; MDR_Out = 16'h9ABC;
    @(negedge Clk); MIO_EN = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    chk("abort pre we_n", SRAM_WE_N, 1'b0);
    Reset = 1'b1;
    #1;
    chk("abort we_n", SRAM_WE_N, 1'b1);
    chk("abort ce_n", SRAM_CE_N, 1'b1);
    chk("abort dq_z", dq_is_z, 1'b1);
    @(negedge Clk); Reset = 1'b0;
    rcnt = 0;
    repeat (8) begin
      @(negedge Clk);
      if (SRAM_R) rcnt++;
    end
    chk("abort no_r", rcnt, 0);
    chk("abort mem_data", Mem_Data, 16'h0000);
    exp_md = 16'h0000; exp_hex = 16'h0000;
    access(1'b1, 16'h3003, 16'h0F0F);
    access(1'b0, 16'h3003, 16'h0000);

    // MMIO address: bypass with the macro, ordinary SRAM without it
    access(1'b0, 16'hFFFF, 16'h0000);
    access(1'b1, 16'hFFFF, 16'h00A5);
    access(1'b0, 16'hFFFF, 16'h0000);

    for (int i = 0; i < 24; i++)
      access(1'($urandom), pool[$urandom_range(0, 5)], 16'($urandom));

    chk("sram_timing_viol", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
